// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFS_W  = 5;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_meta_t;

endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty flags, tags and line data, indexed by set.
// Reads are combinational. A write replaces the whole entry at the edge.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int LINE_W = 256,
  localparam int IW    = $clog2(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IW-1:0]     idx,
  output line_meta_t        rd_meta,
  output logic [LINE_W-1:0] rd_data,
  input  logic              we,
  input  line_meta_t        wr_meta,
  input  logic [LINE_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Flags clear asynchronously so a reset invalidates every line at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= wr_meta.valid;
      dirty_q[idx] <= wr_meta.dirty;
    end
  end

  // Tag and data need no reset: nothing uses them while the valid flag is low.
  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_q[idx]  <= wr_meta.tag;
      data_q[idx] <= wr_data;
    end
  end

  assign rd_meta.valid = valid_q[idx];
  assign rd_meta.dirty = dirty_q[idx];
  assign rd_meta.tag   = tag_q[idx];
  assign rd_data       = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate, direct-mapped data cache controller.
// A hit completes in the MEM-stage cycle. A miss stalls the pipeline while
// the dirty victim is written back and the line is refilled.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | serve hits; a miss picks WRITEBACK or ALLOCATE
//   WRITEBACK | dirty victim line goes out to memory, wait for ack
//   ALLOCATE  | refill read of the requested line, install it on ack
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IW = $clog2(LINES);

  state_t            state_q, state_d;
  line_meta_t        rd_meta, wr_meta;
  logic [LINE_W-1:0] rd_data, wr_data;
  logic              sram_we;

  logic [IW-1:0]     idx;
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        word_sel;
  logic [WORD_W-1:0] rd_word;
  logic              req, is_rd, hit;
  logic              unused_byte_ofs;

  assign idx      = addr_i[OFS_W +: IW];
  assign req_tag  = addr_i[31 -: TAG_W];
  assign word_sel = addr_i[OFS_W-1:2];
  assign req      = MemRead_i | MemWrite_i;
  // A request with both controls high is a store.
  assign is_rd    = MemRead_i & ~MemWrite_i;
  assign hit      = req & rd_meta.valid & (rd_meta.tag == req_tag);
  assign rd_word  = rd_data[{word_sel, 5'b00000} +: WORD_W];
  assign unused_byte_ofs = ^addr_i[1:0];

  dcache_sram #(
    .LINES  (LINES),
    .LINE_W (LINE_W)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx     (idx),
    .rd_meta (rd_meta),
    .rd_data (rd_data),
    .we      (sram_we),
    .wr_meta (wr_meta),
    .wr_data (wr_data)
  );

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: miss chooses write-back first only for a dirty victim.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req && !hit)
                   state_d = (rd_meta.valid && rd_meta.dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: CPU response, memory request and line-store write port.
  always_comb begin
    stall_o      = 1'b0;
    data_o       = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    sram_we      = 1'b0;
    wr_meta      = '0;
    wr_data      = rd_data;
    unique case (state_q)
      IDLE: begin
        stall_o = req & ~hit;
        if (hit && is_rd) data_o = rd_word;
        if (hit && MemWrite_i) begin
          sram_we = 1'b1;
          wr_meta = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          wr_data[{word_sel, 5'b00000} +: WORD_W] = data_i;
        end
      end
      WRITEBACK: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_meta.tag, addr_i[31-TAG_W:OFS_W], {OFS_W{1'b0}}};
        mem_data_o   = rd_data;
      end
      ALLOCATE: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {addr_i[31:OFS_W], {OFS_W{1'b0}}};
        if (mem_ack_i) begin
          sram_we = 1'b1;
          wr_meta = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          wr_data = mem_data_i;
        end
      end
      default: ;
    endcase
    // A held request must not stall the pipeline while reset is asserted.
    if (!rst_i) begin
      stall_o = 1'b0;
      data_o  = '0;
    end
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Write-back, write-allocate, direct-mapped data cache controller placed between the CPU's MEM stage (EX/MEM address, write data and MemRead/MemWrite controls) and a slow 256-bit-line off-chip data memory. Hits complete in the MEM-stage cycle with no stall. Misses raise `stall_o` so the pipeline freezes while the controller writes back a dirty victim and refills the line through a request/ack handshake.

## Interface
- `LINES`, 32: number of cache lines (power of two; index width `IW = log2(LINES)` = 5)
- `LINE_W`, 256: line width in bits (8 words; offset width 5)
- `clk_i`  in  1  single clock; all state updates on rising edge
- `rst_i`  in  1  reset; asynchronous and active-low
- `addr_i`  in  32  CPU byte address (from EX/MEM ALU result)
- `data_i`  in  32  CPU store data
- `MemRead_i`  in  1  load request
- `MemWrite_i`  in  1  store request
- `data_o`  out  32  load data (valid when request is a read and `stall_o`=0)
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- `mem_addr_o`  out  32  line-aligned memory address (`[4:0]`=0)
- `mem_data_o`  out  256  victim line for write-back
- `mem_enable_o`  out  1  memory transaction request
- `mem_write_o`  out  1  1=write-back, 0=refill read
- `mem_data_i`  in  256  refill data
- `mem_ack_i`  in  1  one-cycle completion pulse

## Operation
- Address split: offset `addr_i[4:0]` (word select `[4:2]`, `[1:0]` ignored), index `[9:5]`, tag `[31:10]` (22 bits).
- Per line: valid, dirty, tag, 256-bit data. Hit = request & valid & tag match.
- Request = `MemRead_i | MemWrite_i`. If both are asserted, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
  - IDLE: hit read → `data_o` = selected word combinationally. Hit write → word merged into the line and dirty set at the edge. Miss → `stall_o`=1; go to WRITEBACK if the victim is valid&dirty, else ALLOCATE.
  - WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line. On `mem_ack_i` → ALLOCATE.
  - ALLOCATE: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={req tag, index, 5'b0}. On `mem_ack_i`: line←`mem_data_i`, valid=1, dirty=0, tag←req tag → IDLE.
- After return to IDLE, the still-held request hits and completes as a normal hit; a store on a refilled line sets dirty at that edge.
- `stall_o` = (IDLE & request & ~hit) | WRITEBACK | ALLOCATE.
- `data_o` = 0 whenever the request is not a hit read.
- Memory outputs are 0 in IDLE.

## Timing
- Reset (async, any state): all valid/dirty cleared, state IDLE, `stall_o`/`mem_enable_o`/`mem_write_o`=0, `mem_addr_o`/`mem_data_o`/`data_o`=0. Any in-flight memory transaction is abandoned; a late `mem_ack_i` in IDLE is ignored.
- Hit: 0 stall cycles.
- Clean miss: stall = 1 (IDLE detect) + refill latency L cycles in ALLOCATE (through the ack cycle).
- Dirty miss: 1 + Lw + Lr cycles.
- `mem_enable_o` and all memory address/data outputs stay stable from the first cycle of a state through its ack cycle. WRITEBACK→ALLOCATE is back-to-back: enable stays high, and the memory treats the cycle after an ack as a new transaction.
- `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.
- Request inputs must stay stable while `stall_o`=1, because the pipeline is frozen.

## Structure
- Package `dcache_pkg`:
  - state enum `{IDLE, WRITEBACK, ALLOCATE}`
  - constants `TAG_W`=22, `IDX_W`=5, `OFS_W`=5, `LINE_W`=256
  - line-metadata struct {valid, dirty, tag}
- Sub-module `dcache_sram`: tag/valid/dirty plus data arrays. Combinational read by index; synchronous write of a full entry; async clear of valid/dirty on `rst_i`.
- FSM, hit logic and word merge stay in `dcache_ctrl`.

## Test plan
- Cold read at 0x0000_0400, memory returns line with word1=0xDEAD_BEEF after 10 cycles:
  - request: `stall_o` high 11 cycles, one refill read at 0x400.
  - repeat read of 0x404: `data_o`=0xDEAD_BEEF, no stall.
- Write hit 0x0000_0408 ← 0x1234_5678 on a resident clean line:
  - no stall; line dirty.
  - read 0x408 returns 0x1234_5678.
  - no memory traffic.
- Conflict read 0x0000_0808 (same index, dirty victim):
  - write-back at 0x400 carries 0x1234_5678 in word2.
  - then refill read at 0x800.
  - `stall_o` = 1+Lw+Lr.
- Write miss to a clean line at 0x0000_1000:
  - refill, then merge; line dirty.
  - a later conflicting access at 0x1400 (same index) triggers write-back at 0x1000.
- MemRead_i and MemWrite_i both high on a hit: treated as a store; dirty set.
- `rst_i` low mid-ALLOCATE:
  - `stall_o`/`mem_enable_o` drop immediately; late ack ignored.
  - the previously valid address misses again.
